// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and helpers for the handshaked data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_D  = 3'b011,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101,
        MEM_WU = 3'b110
    } mem_funct3_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BEAT2 = 1'b1
    } dmem_state_e;

    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

    function automatic logic is_legal(input logic [2:0] f3, input int dwidth);
        return !((f3 == 3'b111) ||
                 ((dwidth == 32) && ((f3 == MEM_D) || (f3 == MEM_WU))));
    endfunction

    // Lanes lo..hi-1 enabled; sized for the widest (64-bit) word.
    function automatic logic [7:0] gen_be(input logic [3:0] lo, input logic [3:0] hi);
        logic [7:0] be;
        be = '0;
        for (int i = 0; i < 8; i++) begin
            be[i] = (4'(i) >= lo) && (4'(i) < hi);
        end
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_hs_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_hs_if
// Description : Request/response bus between the LSU and the data memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_hs_if #(
    parameter int AW     = 10,
    parameter int DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [AW-1:0]     req_addr;
    logic [2:0]        req_funct3;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_funct3, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_funct3, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bank
// Description : Word-organised RAM with byte enables and registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bank #(
    parameter  int WORDS  = 256,
    parameter  int DWIDTH = 32,
    localparam int BPW    = DWIDTH / 8,
    localparam int WAW    = $clog2(WORDS)
) (
    input  wire logic              clk,
    input  wire logic              en_i,
    input  wire logic              we_i,
    input  wire logic [BPW-1:0]    be_i,
    input  wire logic [WAW-1:0]    waddr_i,
    input  wire logic [WAW-1:0]    raddr_i,
    input  wire logic [DWIDTH-1:0] wdata_i,
    output logic      [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem_q [WORDS];
    logic [DWIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BPW; b++) begin
                    if (be_i[b]) begin
                        mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_hs.sv
`default_nettype none
// ============================================================================
// Module      : dmem_hs
// Description : Handshaked byte-addressed data memory, B/H/W/D with extension
//               and two-beat handling of word-crossing accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_hs
    import dmem_pkg::*;
#(
    parameter int MEMSIZE          = 'h400,
    parameter int DWIDTH           = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  wire logic  clk,
    input  wire logic  reset,
    dmem_hs_if.slave   bus
);

    localparam int             BPW       = DWIDTH / 8;
    localparam int             AW        = $clog2(MEMSIZE);
    localparam int             OFFW      = $clog2(BPW);
    localparam int             WORDS     = MEMSIZE / BPW;
    localparam int             WAW       = AW - OFFW;
    localparam logic [AW:0]    MEM_LIMIT = (AW+1)'(MEMSIZE);
    localparam logic [3:0]     BPW_B     = 4'(BPW);

    dmem_state_e        state_q, state_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               wen_q;
    logic [2:0]         f3_q;
    logic [OFFW-1:0]    off_q;
    logic [WAW-1:0]     word_q;
    logic [DWIDTH-1:0]  wdata_q;
    logic               split_q;
    logic [DWIDTH-1:0]  beat1_q;

    logic [OFFW-1:0]    w_off;
    logic [WAW-1:0]     w_word;
    logic [3:0]         w_size;
    logic [3:0]         w_end;
    logic [3:0]         w_end_q;
    logic               w_mis, w_oob, w_err, w_accept;

    logic               bank_en, bank_we;
    logic [BPW-1:0]     bank_be;
    logic [WAW-1:0]     bank_addr;
    logic [DWIDTH-1:0]  bank_wdata, bank_rdata;

    logic [DWIDTH-1:0]  w_src_wdata;
    logic [OFFW-1:0]    w_src_off;
    logic [DWIDTH-1:0]  w_wr_lo, w_wr_hi;
    logic [DWIDTH-1:0]  w_ld_lo, w_ld_hi, w_shift, w_ext;
    logic               w_sbit;
    int                 w_nbits;

    // Request decode and legality
    assign w_off    = bus.req_addr[OFFW-1:0];
    assign w_word   = bus.req_addr[AW-1:OFFW];
    assign w_size   = size_bytes(bus.req_funct3);
    assign w_end    = 4'(w_off) + w_size;
    assign w_mis    = w_end > BPW_B;
    assign w_oob    = ({1'b0, bus.req_addr} + (AW+1)'(w_size)) > MEM_LIMIT;
    assign w_err    = (bus.req_wen && bus.req_funct3[2])
                    || !is_legal(bus.req_funct3, DWIDTH)
                    || w_oob
                    || (w_mis && (ALLOW_MISALIGNED == 0));
    assign w_end_q  = 4'(off_q) + size_bytes(f3_q);

    assign bus.req_ready = (state_q == ST_IDLE) && !reset;
    assign w_accept      = bus.req_valid && bus.req_ready;

    // Byte k of store data lands at addr+k: low half feeds beat 1, high half beat 2.
    assign w_src_wdata          = (state_q == ST_BEAT2) ? wdata_q : bus.req_wdata;
    assign w_src_off            = (state_q == ST_BEAT2) ? off_q   : w_off;
    assign {w_wr_hi, w_wr_lo}   = {{DWIDTH{1'b0}}, w_src_wdata} << {w_src_off, 3'b000};

    always_comb begin
        bank_en    = 1'b0;
        bank_we    = 1'b0;
        bank_addr  = w_word;
        bank_be    = BPW'(gen_be(4'(w_off), w_mis ? BPW_B : w_end));
        bank_wdata = w_wr_lo;
        if (state_q == ST_BEAT2) begin
            bank_en    = !reset;
            bank_we    = wen_q;
            bank_addr  = word_q + WAW'(1);
            bank_be    = BPW'(gen_be(4'd0, w_end_q - BPW_B));
            bank_wdata = w_wr_hi;
        end else begin
            bank_en    = w_accept && !w_err;
            bank_we    = bus.req_wen;
        end
    end

    dmem_bank #(
        .WORDS  (WORDS),
        .DWIDTH (DWIDTH)
    ) u_bank (
        .clk     (clk),
        .en_i    (bank_en),
        .we_i    (bank_we),
        .be_i    (bank_be),
        .waddr_i (bank_addr),
        .raddr_i (bank_addr),
        .wdata_i (bank_wdata),
        .rdata_o (bank_rdata)
    );

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    rsp_err_d = w_err;
                    if (w_mis && !w_err) begin
                        state_d = ST_BEAT2;
                    end else begin
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            ST_BEAT2: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Request fields stay valid through BEAT2 and the response cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            wen_q   <= bus.req_wen;
            f3_q    <= bus.req_funct3;
            off_q   <= w_off;
            word_q  <= w_word;
            wdata_q <= bus.req_wdata;
            split_q <= w_mis && !w_err;
        end
        if (state_q == ST_BEAT2) begin
            beat1_q <= bank_rdata;
        end
    end

    // Load assembly and extension
    assign w_ld_lo = split_q ? beat1_q    : bank_rdata;
    assign w_ld_hi = split_q ? bank_rdata : '0;
    assign w_shift = DWIDTH'({w_ld_hi, w_ld_lo} >> {off_q, 3'b000});

    always_comb begin
        w_nbits = 8 << f3_q[1:0];
        case (f3_q[1:0])
            2'd0:    w_sbit = w_shift[7];
            2'd1:    w_sbit = w_shift[15];
            2'd2:    w_sbit = w_shift[31];
            default: w_sbit = w_shift[DWIDTH-1];
        endcase
        if (f3_q[2]) begin
            w_sbit = 1'b0;
        end
        w_ext = '0;
        for (int i = 0; i < DWIDTH; i++) begin
            w_ext[i] = (i < w_nbits) ? w_shift[i] : w_sbit;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = (rsp_valid_q && !rsp_err_q && !wen_q) ? w_ext : '0;

endmodule
`default_nettype wire
